// File: rtl/data_out_mem_if.sv
// Bundle of the pixel write handshake and the readback port for data_out_mem.
// The producer/readback side uses master; the memory block uses slave.
interface data_out_mem_if #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 24
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic             start;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    count;
    logic             done;

    modport master (
        output start, wr_valid, wr_data, rd_addr,
        input  wr_ready, rd_data, count, done
    );

    modport slave (
        input  start, wr_valid, wr_data, rd_addr,
        output wr_ready, rd_data, count, done
    );
endinterface

// File: rtl/data_out_mem.sv
// Output-side pixel memory: captures one frame of DEPTH pixels at
// auto-incrementing addresses and offers a registered readback port.
module data_out_mem #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 24
) (
    input  logic          clk,
    input  logic          rst,
    data_out_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             wr_accept;
    logic [AW-1:0]    wr_addr;

    logic [WIDTH-1:0] mem [DEPTH];

    // start wins over a same-cycle pixel, so that pixel is never stored.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_accept = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_WRITE;
                    count_d = '0;
                end
            end
            ST_WRITE: begin
                if (bus.start) begin
                    count_d = '0;
                end else if (bus.wr_valid) begin
                    wr_accept = 1'b1;
                    count_d   = count_q + CW'(1);
                    if (count_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign wr_addr = count_q[AW-1:0];

    always_comb begin
        rd_data_d = '0;
        if ({1'b0, bus.rd_addr} < DEPTH_EXT) begin
            rd_data_d = mem[bus.rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Contents are never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_addr] <= bus.wr_data;
        end
    end

    assign bus.wr_ready = (state_q == ST_WRITE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.count    = count_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: doc/data_out_mem.md
# data_out_mem

Output-side pixel memory for the vector processor: the write-side counterpart of the input pixel ROM. It accepts processed pixels one per cycle through a valid/ready handshake and stores them at auto-incrementing addresses. It signals when a full frame of `DEPTH` words has been captured. A registered read port lets the testbench, or a later dump stage, read the frame back.

## Interface
- `WIDTH`, default 24: pixel/data word width in bits.
- `DEPTH`, default 24: number of words stored. `AW = $clog2(DEPTH)`. `CW = $clog2(DEPTH+1)`.

- `clk`: input, 1 bit. Single clock; all state updates on its rising edge.
- `rst`: input, 1 bit. One clock; reset is synchronous and active-high.
- `start`: input, 1 bit. Pulse; begins a new frame capture at address 0.
- `wr_valid`: input, 1 bit. Producer has a pixel on `wr_data`.
- `wr_data`: input, `WIDTH` bits. Pixel to store.
- `wr_ready`: output, 1 bit. Block accepts a pixel this cycle.
- `rd_addr`: input, `AW` bits. Readback address.
- `rd_data`: output, `WIDTH` bits. Registered readback data.
- `count`: output, `CW` bits. Pixels written in the current frame.
- `done`: output, 1 bit. Frame complete (`DEPTH` words written).

## Operation
- Storage: `DEPTH x WIDTH` RAM. No reset or clear of contents; contents persist across frames and across `rst`.
- FSM states:
  - IDLE: reset state.
  - WRITE: capturing.
  - DONE: frame held.
- Transitions:
  - IDLE --`start`--> WRITE.
  - WRITE --last accepted write (`count` reaches `DEPTH`)--> DONE.
  - DONE --`start`--> WRITE.
  - WRITE --`start`--> WRITE (restart).
- `wr_ready = (state == WRITE)`, purely combinational from state.
- Accepted write: `wr_valid && wr_ready && !start`.
  - Stores `wr_data` at `RAM[count]`.
  - Increments `count` by 1.
- On entering WRITE via `start`: `count <= 0`, `done <= 0`.
- `start` has priority over a same-cycle `wr_valid`; that pixel is dropped, not stored.
- `wr_valid` in IDLE or DONE is ignored; nothing is written and `count` is unchanged.
- `done = (state == DONE)`, registered with the state.
- Read port:
  - `rd_data <= RAM[rd_addr]` every cycle, in all states.
  - `rd_addr >= DEPTH` returns 0.
  - A read and a write to the same address in the same cycle returns the old contents.
- Width rules:
  - `count` never exceeds `DEPTH`.
  - Write address is `count[AW-1:0]`; it never wraps, because WRITE exits at `DEPTH`.

## Timing
- Reset values (cycle after `rst` high):
  - state IDLE.
  - `wr_ready` = 0.
  - `count` = 0.
  - `done` = 0.
  - `rd_data` = 0.
- `rst` has priority over `start` and writes. Reset mid-frame aborts the capture; already-written RAM words are kept.
- `start` sampled at edge N: `wr_ready` = 1 from cycle N+1.
- Throughput: one pixel per cycle while `wr_valid` is held.
- Last (`DEPTH`-th) write accepted at edge M:
  - At M+1: `count` = `DEPTH`, `done` = 1, `wr_ready` = 0.
  - The stored word is readable from that cycle on.
- Read latency: 1 cycle from `rd_addr` to `rd_data`.
- Stalls: `wr_valid` low in WRITE holds all state. Gaps of any length are allowed.

## Test plan
- Reset:
  - Stimulus: `rst` high 2 cycles, with `start` and `wr_valid` also high.
  - Response: `wr_ready` = 0, `count` = 0, `done` = 0, `rd_data` = 0.
- Full frame:
  - Stimulus: `start`, then 24 back-to-back writes of 0x000000..0x000017.
  - Response:
    - `done` = 1 exactly one cycle after the 24th write.
    - `count` = 24.
    - Reading each address 0..23 returns its index one cycle later.
- Stalls and ignored writes:
  - Stimulus:
    - Write 0xAABBCC, idle 3 cycles with `wr_valid` = 0, then write 0x112233.
    - Then, in DONE, assert `wr_valid` with 0xFFFFFF.
  - Response:
    - `RAM[0]` = 0xAABBCC, `RAM[1]` = 0x112233.
    - The DONE-state write does not change any word or `count`.
- Restart priority:
  - Stimulus: mid-frame at `count` = 10, assert `start` together with `wr_valid` carrying 0x123456.
  - Response:
    - `count` = 0 next cycle; 0x123456 is not stored.
    - The next write lands at address 0.
    - `RAM[1..9]` keep their old values.
- Reset mid-frame:
  - Stimulus: `rst` after 5 writes.
  - Response:
    - State IDLE, `count` = 0, `done` = 0.
    - Readback of addresses 0..4 still returns the written data.
    - Reading address 30 returns 0.
